ph_host_port: RTL and testbench

PH_HOST_PORT -- requirements
Module: ph_host_port

---
 rtl/ph_host_port_if.sv | 28 ++
 rtl/ph_host_port.sv | 124 ++++++++++++
 tb/tb_ph_host_port.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ph_host_port_if.sv
// Host register bus and upstream FIFO read port of the parasite host port.
// Strobe semantics: h_cs is a single-cycle access strobe that needs no ready.
// The access completes at the rising edge that closes the strobe cycle.
// f_rd_en is a pop request that the FIFO always honours while f_empty=0.
// The popped byte appears on f_data in the following cycle.
interface ph_host_port_if;
   logic       h_cs;
   logic       h_a;
   logic       h_rd;
   logic [7:0] h_din;
   logic [7:0] h_dout;
   logic       h_irq;
   logic [7:0] f_data;
   logic       f_empty;
   logic       f_rd_en;

   // Host and FIFO side (drives accesses, supplies FIFO data).
   modport master (
      output h_cs, h_a, h_rd, h_din, f_data, f_empty,
      input  h_dout, h_irq, f_rd_en
   );

   // The host port block itself.
   modport slave (
      input  h_cs, h_a, h_rd, h_din, f_data, f_empty,
      output h_dout, h_irq, f_rd_en
   );
endinterface

// File: rtl/ph_host_port.sv
// Host-side port for the parasite-to-host byte channel.
// A two-entry prefetch buffer is kept filled from the upstream FIFO.
// It is exposed to the host as a status/control register and a data register.
module ph_host_port (
   input  logic                 h_phi2,
   input  logic                 h_rst,
   ph_host_port_if.slave        bus,
   output logic                 dbg_fetch
);

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} fetch_state_t;

   fetch_state_t state;
   logic         in_flight;
   logic         rst_done;
   logic [7:0]   head;
   logic [7:0]   tail;
   logic [1:0]   count;
   logic         irq_en;
   logic         two_byte;
   logic         underflow;
   logic         irq_q;

   logic         data_rd;
   logic         ctrl_wr;
   logic         pop;
   logic         capture;
   logic         fetch_go;
   logic         avail;
   logic         unused_din;

   assign data_rd  = bus.h_cs & bus.h_a & bus.h_rd;
   assign ctrl_wr  = bus.h_cs & ~bus.h_a & ~bus.h_rd;
   assign pop      = data_rd & (count != 2'd0);
   assign capture  = (state == FETCH);
   // rst_done keeps the first pop request off until one edge after reset release.
   assign fetch_go = rst_done & (state == IDLE) & ~bus.f_empty & (count < 2'd2);
   assign avail    = two_byte ? (count == 2'd2) : (count != 2'd0);

   assign bus.f_rd_en = fetch_go;
   assign bus.h_irq   = irq_q;
   assign dbg_fetch   = in_flight;
   assign unused_din  = ^{bus.h_din[7], bus.h_din[3:0]};

   // Fetch FSM: one pop request, then one capture cycle, so at most one byte is in flight.
   always_ff @(posedge h_phi2 or posedge h_rst) begin
      if (h_rst) begin
         state     <= IDLE;
         in_flight <= 1'b0;
         rst_done  <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         case (state)
            IDLE: begin
               if (fetch_go) begin
                  state     <= FETCH;
                  in_flight <= 1'b1;
               end
            end
            FETCH: begin
               state     <= IDLE;
               in_flight <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               in_flight <= 1'b0;
            end
         endcase
      end
   end

   // Prefetch buffer: head is always the oldest byte; pop and capture on one edge keep order.
   always_ff @(posedge h_phi2 or posedge h_rst) begin
      if (h_rst) begin
         head  <= 8'h00;
         tail  <= 8'h00;
         count <= 2'd0;
      end else begin
         if (pop && capture) begin
            if (count == 2'd1) begin
               head <= bus.f_data;
            end else begin
               head <= tail;
               tail <= bus.f_data;
            end
         end else if (pop) begin
            head  <= tail;
            count <= count - 2'd1;
         end else if (capture) begin
            if (count == 2'd0) head <= bus.f_data;
            else               tail <= bus.f_data;
            count <= count + 2'd1;
         end
      end
   end

   // Control register, sticky underflow and the registered interrupt request.
   always_ff @(posedge h_phi2 or posedge h_rst) begin
      if (h_rst) begin
         irq_en    <= 1'b0;
         two_byte  <= 1'b0;
         underflow <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         irq_q <= irq_en & avail;
         if (ctrl_wr) begin
            irq_en   <= bus.h_din[5];
            two_byte <= bus.h_din[6];
            if (bus.h_din[4]) underflow <= 1'b0;
         end
         if (data_rd && (count == 2'd0)) underflow <= 1'b1;
      end
   end

   // Host read mux: data or status during a read strobe, zero otherwise.
   always_comb begin
      bus.h_dout = 8'h00;
      if (!h_rst && bus.h_cs && bus.h_rd) begin
         if (bus.h_a) bus.h_dout = (count != 2'd0) ? head : 8'hAA;
         else         bus.h_dout = {avail, two_byte, irq_en, underflow, 4'b0000};
      end
   end

endmodule

// File: tb/tb_ph_host_port.sv
// Directed bench for ph_host_port with a small behavioural upstream FIFO.
module tb_ph_host_port;

  logic h_phi2;
  logic h_rst;
  logic dbg_fetch;
  int   checks;
  int   failures;
  int   rd_pulses;

  ph_host_port_if bus ();

  ph_host_port dut (
    .h_phi2    (h_phi2),
    .h_rst     (h_rst),
    .bus       (bus.slave),
    .dbg_fetch (dbg_fetch)
  );

  // clock/reset block
  initial h_phi2 = 1'b0;
  always #5 h_phi2 = ~h_phi2;

  // upstream FIFO model: pops on f_rd_en, data valid the next cycle, cleared by h_rst
  logic [7:0] fifo_mem [0:15];
  int         wr_ptr;
  int         rd_ptr;

  assign bus.f_empty = (wr_ptr == rd_ptr);

  always @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      rd_ptr <= wr_ptr;
    end else if (bus.f_rd_en && (wr_ptr != rd_ptr)) begin
      bus.f_data <= fifo_mem[rd_ptr[3:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(posedge h_phi2) begin
    if (bus.f_rd_en) rd_pulses++;
  end

  // driver tasks
  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge h_phi2);
  endtask

  task automatic host_read(input logic a, output logic [7:0] d);
    @(negedge h_phi2);
    bus.h_cs = 1'b1; bus.h_a = a; bus.h_rd = 1'b1;
    #1 d = bus.h_dout;
    @(posedge h_phi2);
    #1 bus.h_cs = 1'b0; bus.h_rd = 1'b0; bus.h_a = 1'b0;
  endtask

  task automatic host_write(input logic a, input logic [7:0] d);
    @(negedge h_phi2);
    bus.h_cs = 1'b1; bus.h_a = a; bus.h_rd = 1'b0; bus.h_din = d;
    @(posedge h_phi2);
    #1 bus.h_cs = 1'b0; bus.h_a = 1'b0; bus.h_din = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    idle(2);
    checks++; if (bus.h_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got %b exp 0", bus.h_irq); end
    checks++; if (bus.f_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got %b exp 0", bus.f_rd_en); end
    checks++; if (dbg_fetch !== 1'b0) begin failures++; $display("FAIL rst_state got %b exp 0", dbg_fetch); end
    bus.h_cs = 1'b1; bus.h_a = 1'b1; bus.h_rd = 1'b1;
    #1;
    checks++; if (bus.h_dout !== 8'h00) begin failures++; $display("FAIL rst_dout got %h exp 00", bus.h_dout); end
    @(negedge h_phi2);
    bus.h_cs = 1'b0; bus.h_a = 1'b0; bus.h_rd = 1'b0;
    h_rst = 1'b0;
    push(8'h5A);
    #1;
    checks++; if (bus.f_rd_en !== 1'b0) begin failures++; $display("FAIL release_rd_en got %b exp 0", bus.f_rd_en); end
    @(negedge h_phi2);
    checks++; if (bus.f_rd_en !== 1'b1) begin failures++; $display("FAIL first_rd_en got %b exp 1", bus.f_rd_en); end
    @(negedge h_phi2);
    checks++; if ((bus.f_rd_en !== 1'b0) || (dbg_fetch !== 1'b1)) begin failures++; $display("FAIL fetch_state got rd_en=%b fetch=%b exp 0/1", bus.f_rd_en, dbg_fetch); end
    idle(2);
    host_read(1'b1, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rst_drain got %h exp 5a", d); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int p0;
    p0 = rd_pulses;
    @(negedge h_phi2); push(8'h41);
    idle(4);
    checks++; if (rd_pulses - p0 !== 1) begin failures++; $display("FAIL single_pulses got %0d exp 1", rd_pulses - p0); end
    host_read(1'b0, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL single_status got %h exp 80", d); end
    host_read(1'b1, d);
    checks++; if (d !== 8'h41) begin failures++; $display("FAIL single_data got %h exp 41", d); end
    host_read(1'b0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL single_status2 got %h exp 00", d); end
  endtask

  task automatic test_multi();
    logic [7:0] d;
    logic [7:0] exp_d [4];
    int p0;
    exp_d = '{8'h01, 8'h02, 8'h03, 8'hAA};
    p0 = rd_pulses;
    @(negedge h_phi2); push(8'h01); push(8'h02); push(8'h03);
    idle(6);
    checks++; if (rd_pulses - p0 !== 2) begin failures++; $display("FAIL multi_pulses got %0d exp 2", rd_pulses - p0); end
    for (int i = 0; i < 4; i++) begin
      host_read(1'b1, d);
      checks++; if (d !== exp_d[i]) begin failures++; $display("FAIL multi_data%0d got %h exp %h", i, d, exp_d[i]); end
      idle(3);
    end
    host_read(1'b0, d);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL multi_underflow got %h exp 10", d); end
    host_write(1'b1, 8'h60);
    host_read(1'b0, d);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL data_write_ignored got %h exp 10", d); end
    host_write(1'b0, 8'h10);
    host_read(1'b0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL underflow_clear got %h exp 00", d); end
  endtask

  task automatic test_two_byte();
    logic [7:0] d;
    host_write(1'b0, 8'h40);
    @(negedge h_phi2); push(8'h11);
    idle(4);
    host_read(1'b0, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL two_status1 got %h exp 40", d); end
    checks++; if (bus.h_irq !== 1'b0) begin failures++; $display("FAIL two_irq got %b exp 0", bus.h_irq); end
    @(negedge h_phi2); push(8'h22);
    idle(4);
    host_read(1'b0, d);
    checks++; if (d !== 8'hC0) begin failures++; $display("FAIL two_status2 got %h exp c0", d); end
    host_read(1'b1, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL two_data1 got %h exp 11", d); end
    idle(4);
    host_read(1'b0, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL two_status3 got %h exp 40", d); end
    host_read(1'b1, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL two_data2 got %h exp 22", d); end
    host_write(1'b0, 8'h00);
  endtask

  task automatic test_irq();
    logic [7:0] d;
    host_write(1'b0, 8'h20);
    @(negedge h_phi2); push(8'h33);
    @(negedge h_phi2);
    checks++; if (dbg_fetch !== 1'b1) begin failures++; $display("FAIL irq_fetch got %b exp 1", dbg_fetch); end
    @(negedge h_phi2);
    checks++; if (bus.h_irq !== 1'b0) begin failures++; $display("FAIL irq_early got %b exp 0", bus.h_irq); end
    @(negedge h_phi2);
    checks++; if (bus.h_irq !== 1'b1) begin failures++; $display("FAIL irq_rise got %b exp 1", bus.h_irq); end
    host_read(1'b1, d);
    checks++; if (d !== 8'h33) begin failures++; $display("FAIL irq_data got %h exp 33", d); end
    @(negedge h_phi2);
    checks++; if (bus.h_irq !== 1'b1) begin failures++; $display("FAIL irq_hold got %b exp 1", bus.h_irq); end
    @(negedge h_phi2);
    checks++; if (bus.h_irq !== 1'b0) begin failures++; $display("FAIL irq_fall got %b exp 0", bus.h_irq); end
    host_write(1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    @(negedge h_phi2); push(8'hA1);
    idle(4);
    @(negedge h_phi2); push(8'hA2);
    @(negedge h_phi2);
    checks++; if (dbg_fetch !== 1'b1) begin failures++; $display("FAIL b2b_fetch got %b exp 1", dbg_fetch); end
    bus.h_cs = 1'b1; bus.h_a = 1'b1; bus.h_rd = 1'b1;
    #1 d = bus.h_dout;
    @(posedge h_phi2);
    #1 bus.h_cs = 1'b0; bus.h_a = 1'b0; bus.h_rd = 1'b0;
    checks++; if (d !== 8'hA1) begin failures++; $display("FAIL b2b_data1 got %h exp a1", d); end
    host_read(1'b0, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL b2b_status got %h exp 80", d); end
    host_read(1'b1, d);
    checks++; if (d !== 8'hA2) begin failures++; $display("FAIL b2b_data2 got %h exp a2", d); end
    host_read(1'b0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL b2b_empty got %h exp 00", d); end
  endtask

  task automatic test_reset_in_fetch();
    logic [7:0] d;
    int p0;
    host_write(1'b0, 8'h20);
    @(negedge h_phi2); push(8'hB1);
    idle(4);
    checks++; if (bus.h_irq !== 1'b1) begin failures++; $display("FAIL rf_irq_pre got %b exp 1", bus.h_irq); end
    @(negedge h_phi2); push(8'hB2);
    @(negedge h_phi2);
    checks++; if (dbg_fetch !== 1'b1) begin failures++; $display("FAIL rf_fetch got %b exp 1", dbg_fetch); end
    h_rst = 1'b1;
    bus.h_cs = 1'b1; bus.h_a = 1'b0; bus.h_rd = 1'b1;
    #1;
    checks++; if (bus.h_irq !== 1'b0) begin failures++; $display("FAIL rf_irq got %b exp 0", bus.h_irq); end
    checks++; if (dbg_fetch !== 1'b0) begin failures++; $display("FAIL rf_state got %b exp 0", dbg_fetch); end
    checks++; if (bus.h_dout !== 8'h00) begin failures++; $display("FAIL rf_dout got %h exp 00", bus.h_dout); end
    checks++; if (bus.f_rd_en !== 1'b0) begin failures++; $display("FAIL rf_rd_en got %b exp 0", bus.f_rd_en); end
    @(negedge h_phi2);
    bus.h_cs = 1'b0; bus.h_rd = 1'b0;
    h_rst = 1'b0;
    p0 = rd_pulses;
    idle(6);
    checks++; if (rd_pulses !== p0) begin failures++; $display("FAIL rf_pulses got %0d exp %0d", rd_pulses, p0); end
    host_read(1'b0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rf_status got %h exp 00", d); end
    host_read(1'b1, d);
    checks++; if (d !== 8'hAA) begin failures++; $display("FAIL rf_data got %h exp aa", d); end
    host_read(1'b0, d);
    checks++; if (d !== 8'h10) begin failures++; $display("FAIL rf_underflow got %h exp 10", d); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rd_pulses = 0;
    wr_ptr    = 0;
    h_rst     = 1'b1;
    bus.h_cs  = 1'b0;
    bus.h_a   = 1'b0;
    bus.h_rd  = 1'b0;
    bus.h_din = 8'h00;
    test_reset();
    test_single();
    test_multi();
    test_two_byte();
    test_irq();
    test_back_to_back();
    test_reset_in_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
